// File: rtl/count_sequencer.sv
// count_sequencer: synchronised, debounced button controller that steps a
// WIDTH-bit LED counter up/down, with clear and hold-to-auto-repeat.
module count_sequencer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             upButton,
  input  logic             downButton,
  input  logic             clearButton,
  input  logic             enableSwitch,
  output logic [WIDTH-1:0] LEDS,
  output logic             stepPulse,
  output logic             wrapPulse
);

  localparam int UP_IDX  = 0;
  localparam int DN_IDX  = 1;
  localparam int CLR_IDX = 2;
  localparam int EN_IDX  = 3;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       deb_r;
  logic [DB_W-1:0]  db_cnt_r [4];
  logic [2:0]       deb_prev_r;
  logic [2:0]       armed_r;
  logic [1:0]       settle_r;
  logic [2:0]       rise_s;
  logic             up_press_s;
  logic             down_press_s;
  logic             clear_press_s;
  logic             held_s;
  state_t           state_r;
  dir_t             dir_r;
  logic [TMR_W-1:0] timer_r;
  logic [WIDTH-1:0] count_r;
  logic             step_r;
  logic             wrap_r;

  // Returns {wrap, next_count} for a single modulo-2^WIDTH step.
  function automatic logic [WIDTH:0] step_value(input logic [WIDTH-1:0] cur, input logic up);
    logic [WIDTH:0] res;
    if (up) begin
      res = {(cur == {WIDTH{1'b1}}), cur + WIDTH'(1)};
    end else begin
      res = {(cur == {WIDTH{1'b0}}), cur - WIDTH'(1)};
    end
    return res;
  endfunction

  assign raw_s = {enableSwitch, clearButton, downButton, upButton};

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_r <= 4'b0;
      sync2_r <= 4'b0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debouncers: a level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      deb_r      <= 4'b0;
      deb_prev_r <= 3'b0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      deb_prev_r <= deb_r[2:0];
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_r[i]    <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // A button held through reset must be seen released before it can press again;
  // settle_r waits for the synchroniser to refill before trusting its output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      settle_r <= 2'd0;
      armed_r  <= 3'b0;
    end else begin
      if (settle_r != 2'd2) begin
        settle_r <= settle_r + 2'd1;
      end
      armed_r <= armed_r | ({3{settle_r == 2'd2}} & ~sync2_r[2:0]);
    end
  end

  // Press events and the held level of the latched direction.
  always_comb begin
    rise_s        = deb_r[2:0] & ~deb_prev_r & armed_r;
    up_press_s    = rise_s[UP_IDX] & deb_r[EN_IDX];
    down_press_s  = rise_s[DN_IDX] & deb_r[EN_IDX];
    clear_press_s = rise_s[CLR_IDX];
    if (dir_r == DIR_UP) begin
      held_s = deb_r[UP_IDX];
    end else begin
      held_s = deb_r[DN_IDX];
    end
  end

  // Direction FSM, repeat timer and registered count/pulse outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
      dir_r   <= DIR_UP;
      timer_r <= '0;
      count_r <= '0;
      step_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      step_r <= 1'b0;
      wrap_r <= 1'b0;
      if (clear_press_s) begin
        count_r <= '0;
        state_r <= IDLE;
        timer_r <= '0;
      end else if (!deb_r[EN_IDX]) begin
        state_r <= IDLE;
        timer_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (up_press_s ^ down_press_s) begin
              dir_r             <= up_press_s ? DIR_UP : DIR_DOWN;
              state_r           <= HOLD;
              timer_r           <= TMR_W'(REPEAT_DELAY - 1);
              {wrap_r, count_r} <= step_value(count_r, up_press_s);
              step_r            <= 1'b1;
            end
          end
          HOLD, REPEAT: begin
            if (!held_s) begin
              state_r <= IDLE;
              timer_r <= '0;
            end else if (timer_r == '0) begin
              state_r           <= REPEAT;
              timer_r           <= TMR_W'(REPEAT_PERIOD - 1);
              {wrap_r, count_r} <= step_value(count_r, dir_r == DIR_UP);
              step_r            <= 1'b1;
            end else begin
              timer_r <= timer_r - TMR_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            timer_r <= '0;
          end
        endcase
      end
    end
  end

  assign LEDS      = count_r;
  assign stepPulse = step_r;
  assign wrapPulse = wrap_r;

endmodule
